// File: rtl/ucie_ctl_phy_sb_msg_interface_rx.sv
// rtl/ucie_ctl_phy_sb_msg_interface_rx.sv - sideband RX message buffer delivering words to RDI pl_cfg under Adapter credits
//
// Purpose:
//   Buffers NC-bit sideband words from the deserializer in a small FIFO and delivers them
//   to the Adapter on pl_cfg / pl_cfg_vld. Each delivery spends one Adapter credit, and
//   lp_cfg_crd pulses return credits. A word written at an edge is delivered (valid high)
//   two cycles later at the earliest; there is no empty-FIFO bypass.
//
// Configuration macro:
//   SB_RX_OVERFLOW_DETECT_EN - when defined, o_sb_rx_overflow is a sticky flag that sets when
//   a word arrives while the FIFO is full and nothing pops. When not defined it is tied to 0.
//   Overflow words are dropped in both builds.
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_sb_data_valid       sideband word valid, one cycle per word
//   i_data_rcvd_sb        sideband word
//   o_sb_rx_ready         FIFO not full (informational only, no backpressure)
//   i_rdi_lp_cfg_crd      Adapter credit return, one credit per high cycle
//   o_rdi_pl_cfg_valid    pl_cfg_vld, one word per high cycle
//   o_rdi_pl_cfg          pl_cfg data, holds its last value while valid is low
//   o_sb_rx_overflow      sticky overflow flag

`ifndef NC
`define NC 32
`endif

module ucie_ctl_phy_sb_msg_interface_rx #(
  parameter int NC         = `NC,
  parameter int FIFO_DEPTH = 4,
  parameter int CRD_MAX    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_sb_data_valid,
  input  logic [NC-1:0] i_data_rcvd_sb,
  output logic          o_sb_rx_ready,
  input  logic          i_rdi_lp_cfg_crd,
  output logic          o_rdi_pl_cfg_valid,
  output logic [NC-1:0] o_rdi_pl_cfg,
  output logic          o_sb_rx_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(CRD_MAX + 1);
  localparam logic [CW-1:0] CRD_MAX_C = CW'(CRD_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    STALL = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   crd_cnt;
  logic [NC-1:0]   mem [FIFO_DEPTH];
  logic [NC-1:0]   pl_cfg_q;
  logic            fifo_full, fifo_empty;
  logic            pop, push;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign pop  = !fifo_empty && (crd_cnt != '0);
  // A full FIFO still accepts a word when the head leaves at the same edge.
  assign push = i_sb_data_valid && (!fifo_full || pop);

  assign o_sb_rx_ready = !fifo_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data_rcvd_sb;
  end

  // Return and spend on the same edge cancel; returns beyond CRD_MAX are ignored.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crd_cnt <= CRD_MAX_C;
    end else if (pop && !i_rdi_lp_cfg_crd) begin
      crd_cnt <= crd_cnt - CW'(1);
    end else if (!pop && i_rdi_lp_cfg_crd && (crd_cnt < CRD_MAX_C)) begin
      crd_cnt <= crd_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pl_cfg_q <= '0;
    end else if (pop) begin
      pl_cfg_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // SEND is entered exactly on a pop edge, so being in SEND means a word is on pl_cfg.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (pop)              state_d = SEND;
        else if (!fifo_empty) state_d = STALL;
      end
      SEND: begin
        if (pop)             state_d = SEND;
        else if (fifo_empty) state_d = IDLE;
        else                 state_d = STALL;
      end
      STALL: begin
        if (pop)             state_d = SEND;
        else if (fifo_empty) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_rdi_pl_cfg_valid = (state_q == SEND);
  assign o_rdi_pl_cfg       = pl_cfg_q;

`ifdef SB_RX_OVERFLOW_DETECT_EN
  logic overflow_q;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) overflow_q <= 1'b0;
    else if (i_sb_data_valid && fifo_full && !pop) overflow_q <= 1'b1;
  end
  assign o_sb_rx_overflow = overflow_q;
`else
  assign o_sb_rx_overflow = 1'b0;
`endif

endmodule
